// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared constants, opcodes and state/register types for the memory stage
package processor_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int REG_W  = 4;

    localparam logic [3:0] OP_LW = 4'h8;
    localparam logic [3:0] OP_SW = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] bout;
        logic [REG_W-1:0]  rd;
        logic [3:0]        op;
        logic              regwrite;
        logic              pcwrite;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              pcwrite;
        logic              misalign;
    } mem_wb_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - req/gnt/rvalid bus FSM producing stall and a completion pulse
module mem_bus_ctrl
    import processor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              done
);

    mem_state_e state_q, state_d;

    // Address, direction and data come straight from the EX/MEM register,
    // which is frozen by stall, so they stay stable for the whole access.
    assign mem_addr  = addr;
    assign mem_we    = is_store;
    assign mem_wdata = wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus request and stall; stall drops in the completing cycle
    // so the EX/MEM and MEM/WB registers advance on that same edge.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_gnt) begin
                    if (is_store) begin
                        stall   = 1'b0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    stall   = 1'b0;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - memory stage: EX/MEM and MEM/WB registers, wb mux; MEM_ALIGN_CHECK_EN enables misaligned-access trap
module memory_cycle
    import processor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluout,
    input  logic [DATA_W-1:0] ex_bout,
    input  logic [REG_W-1:0]  ex_rdout,
    input  logic [3:0]        ex_opout,
    input  logic              ex_regwrite,
    input  logic              ex_pcwrite,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] new_mem_aluout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_regwrite,
    output logic              wb_pcwrite,
    output logic              misalign
);

    ex_mem_t exm_q, exm_d;
    mem_wb_t mwb_q, mwb_d;

    logic is_mem;
    logic is_store;
    logic mis_addr;
    logic start;
    logic done;

    assign is_mem   = is_mem_op(exm_q.op);
    assign is_store = (exm_q.op == OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_addr = exm_q.aluout[0];
`else
    assign mis_addr = 1'b0;
`endif

    // A misaligned access never reaches the bus; a flushed one is never started.
    assign start = exm_q.valid && is_mem && !mis_addr && !flush;

    mem_bus_ctrl u_bus (
        .clk        (clk),
        .rst_n      (rst),
        .start      (start),
        .is_store   (is_store),
        .flush      (flush),
        .addr       (exm_q.aluout),
        .wdata      (exm_q.bout),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .done       (done)
    );

    // EX/MEM next value: load when not stalled, otherwise hold; flush always kills valid.
    always_comb begin
        exm_d = exm_q;
        if (!stall) begin
            exm_d.valid    = ex_valid && !flush;
            exm_d.aluout   = ex_aluout;
            exm_d.bout     = ex_bout;
            exm_d.rd       = ex_rdout;
            exm_d.op       = ex_opout;
            exm_d.regwrite = ex_regwrite;
            exm_d.pcwrite  = ex_pcwrite;
        end else if (flush) begin
            exm_d.valid = 1'b0;
        end
    end

    // MEM/WB next value: a bubble while stalled, else the retiring instruction with load data muxed in.
    always_comb begin
        mwb_d = '0;
        if (!stall) begin
            mwb_d.valid    = exm_q.valid && !flush;
            mwb_d.data     = (done && !is_store) ? mem_rdata : exm_q.aluout;
            mwb_d.rd       = exm_q.rd;
            mwb_d.regwrite = exm_q.regwrite && !is_store && !(is_mem && mis_addr);
            mwb_d.pcwrite  = exm_q.pcwrite && !(is_mem && mis_addr);
            mwb_d.misalign = exm_q.valid && !flush && is_mem && mis_addr;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_q <= '0;
            mwb_q <= '0;
        end else begin
            exm_q <= exm_d;
            mwb_q <= mwb_d;
        end
    end

    assign new_mem_aluout = exm_q.aluout;
    assign wb_valid       = mwb_q.valid;
    assign wb_data        = mwb_q.data;
    assign wb_rd          = mwb_q.rd;
    assign wb_regwrite    = mwb_q.valid && mwb_q.regwrite;
    assign wb_pcwrite     = mwb_q.valid && mwb_q.pcwrite;
    assign misalign       = mwb_q.valid && mwb_q.misalign;

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - directed self-checking bench for memory_cycle
module tb_memory_cycle;
    import processor_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_aluout;
    logic [DATA_W-1:0] ex_bout;
    logic [REG_W-1:0]  ex_rdout;
    logic [3:0]        ex_opout;
    logic              ex_regwrite;
    logic              ex_pcwrite;
    logic              flush;
    logic              stall;
    logic [DATA_W-1:0] new_mem_aluout;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_regwrite;
    logic              wb_pcwrite;
    logic              misalign;

    int checks   = 0;
    int failures = 0;
    int n_stall;

    always #5 clk = ~clk;

    memory_cycle dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_aluout      (ex_aluout),
        .ex_bout        (ex_bout),
        .ex_rdout       (ex_rdout),
        .ex_opout       (ex_opout),
        .ex_regwrite    (ex_regwrite),
        .ex_pcwrite     (ex_pcwrite),
        .flush          (flush),
        .stall          (stall),
        .new_mem_aluout (new_mem_aluout),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .wb_pcwrite     (wb_pcwrite),
        .misalign       (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction for one accepting edge, then withdraw it.
    task automatic issue(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] bv,
                         input logic [3:0] rd, input logic rw, input logic pw);
        ex_valid    = 1'b1;
        ex_opout    = op;
        ex_aluout   = alu;
        ex_bout     = bv;
        ex_rdout    = rd;
        ex_regwrite = rw;
        ex_pcwrite  = pw;
        cyc();
        ex_valid    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_aluout = '0; ex_bout = '0; ex_rdout = '0;
        ex_opout = '0; ex_regwrite = 1'b0; ex_pcwrite = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_fwd", new_mem_aluout, 0);
        rst = 1'b1;
        cyc();

        // 1: ALU op passes through in two clocks without stall
        issue(4'h1, 16'h1234, 16'h0, 4'd3, 1'b1, 1'b0);
        #1;
        chk("t1_c0_stall", stall, 0);
        chk("t1_c0_wbv", wb_valid, 0);
        chk("t1_fwd", new_mem_aluout, 16'h1234);
        cyc(); #1;
        chk("t1_stall", stall, 0);
        chk("t1_wbv", wb_valid, 1);
        chk("t1_data", wb_data, 16'h1234);
        chk("t1_rd", wb_rd, 3);
        chk("t1_rw", wb_regwrite, 1);
        chk("t1_pw", wb_pcwrite, 0);
        cyc(); #1;
        chk("t1_wbv_after", wb_valid, 0);

        // 2: load, immediate gnt, rvalid after three WAIT clocks
        issue(OP_LW, 16'h0100, 16'h0, 4'd5, 1'b1, 1'b0);
        #1;
        chk("t2_c0_stall", stall, 1);
        chk("t2_c0_req", mem_req, 0);
        n_stall = int'(stall);
        cyc(); mem_gnt = 1'b1; #1;
        chk("t2_req", mem_req, 1);
        chk("t2_we", mem_we, 0);
        chk("t2_addr", mem_addr, 16'h0100);
        n_stall += int'(stall);
        cyc(); mem_gnt = 1'b0; #1;
        chk("t2_wait_req", mem_req, 0);
        chk("t2_wait_wbv", wb_valid, 0);
        n_stall += int'(stall);
        cyc(); #1; n_stall += int'(stall);
        cyc(); #1; n_stall += int'(stall);
        cyc(); mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("t2_rv_stall", stall, 0);
        n_stall += int'(stall);
        chk("t2_stall_cycles", n_stall, 5);
        cyc(); mem_rvalid = 1'b0; mem_rdata = 16'h0; #1;
        chk("t2_wbv", wb_valid, 1);
        chk("t2_data", wb_data, 16'hBEEF);
        chk("t2_rd", wb_rd, 5);
        chk("t2_rw", wb_regwrite, 1);

        // 3: store with gnt delayed two clocks
        issue(OP_SW, 16'h0040, 16'h00AA, 4'd7, 1'b1, 1'b0);
        cyc(); #1;
        chk("t3_r0_req", mem_req, 1);
        chk("t3_r0_we", mem_we, 1);
        chk("t3_r0_addr", mem_addr, 16'h0040);
        chk("t3_r0_wdata", mem_wdata, 16'h00AA);
        cyc(); #1;
        chk("t3_r1_req", mem_req, 1);
        chk("t3_r1_addr", mem_addr, 16'h0040);
        chk("t3_r1_wdata", mem_wdata, 16'h00AA);
        chk("t3_r1_stall", stall, 1);
        cyc(); mem_gnt = 1'b1; #1;
        chk("t3_gnt_req", mem_req, 1);
        chk("t3_gnt_stall", stall, 0);
        cyc(); mem_gnt = 1'b0; #1;
        chk("t3_wbv", wb_valid, 1);
        chk("t3_rw", wb_regwrite, 0);
        chk("t3_req_off", mem_req, 0);
        cyc(); #1;
        chk("t3_single_wb", wb_valid, 0);

        // 4: load flushed while waiting for data
        issue(OP_LW, 16'h0200, 16'h0, 4'd2, 1'b1, 1'b0);
        cyc(); mem_gnt = 1'b1; #1;
        chk("t4_req", mem_req, 1);
        cyc(); mem_gnt = 1'b0; flush = 1'b1; #1;
        chk("t4_flush_stall", stall, 1);
        cyc(); flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5555; #1;
        chk("t4_rv_stall", stall, 0);
        cyc(); mem_rvalid = 1'b0; mem_rdata = 16'h0; #1;
        chk("t4_no_wb", wb_valid, 0);
        chk("t4_idle_stall", stall, 0);
        chk("t4_idle_req", mem_req, 0);
        issue(4'h2, 16'h00C3, 16'h0, 4'd1, 1'b1, 1'b0);
        #1;
        chk("t4_alu_stall", stall, 0);
        cyc(); #1;
        chk("t4_alu_wbv", wb_valid, 1);
        chk("t4_alu_data", wb_data, 16'h00C3);
        chk("t4_alu_rd", wb_rd, 1);

        // 5: asynchronous reset while a request is pending
        issue(OP_LW, 16'h0300, 16'h0, 4'd6, 1'b1, 1'b0);
        cyc(); #1;
        chk("t5_req_before", mem_req, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_req_async", mem_req, 0);
        chk("t5_stall_async", stall, 0);
        chk("t5_wbv_async", wb_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(); #1;
        chk("t5_idle_req", mem_req, 0);
        chk("t5_idle_stall", stall, 0);
        issue(4'h3, 16'hA5A5, 16'h0, 4'd9, 1'b1, 1'b1);
        cyc(); #1;
        chk("t5_alu_wbv", wb_valid, 1);
        chk("t5_alu_data", wb_data, 16'hA5A5);
        chk("t5_alu_pw", wb_pcwrite, 1);

        // 6: odd address load
`ifdef MEM_ALIGN_CHECK_EN
        issue(OP_LW, 16'h0003, 16'h0, 4'd4, 1'b1, 1'b1);
        #1;
        chk("t6_stall", stall, 0);
        chk("t6_req", mem_req, 0);
        cyc(); #1;
        chk("t6_misalign", misalign, 1);
        chk("t6_wbv", wb_valid, 1);
        chk("t6_rw", wb_regwrite, 0);
        chk("t6_pw", wb_pcwrite, 0);
        chk("t6_req2", mem_req, 0);
        cyc(); #1;
        chk("t6_misalign_pulse", misalign, 0);
`else
        issue(OP_LW, 16'h0003, 16'h0, 4'd4, 1'b1, 1'b0);
        #1;
        chk("t6_stall", stall, 1);
        cyc(); mem_gnt = 1'b1; #1;
        chk("t6_req", mem_req, 1);
        chk("t6_addr", mem_addr, 16'h0003);
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1357; #1;
        chk("t6_misalign", misalign, 0);
        cyc(); mem_rvalid = 1'b0; #1;
        chk("t6_wbv", wb_valid, 1);
        chk("t6_data", wb_data, 16'h1357);
        chk("t6_misalign_wb", misalign, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
